// File: rtl/pixel_writeback_fifo.sv
// Buffers raycaster pixel writes and drains each one as three 32-bit writes on a
// valid/ready memory bus; re-times frame_done behind the last pixel of the frame.
module pixel_writeback_fifo #(
  parameter int          DEPTH   = 16,
  parameter logic [31:0] FB_BASE = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_pixel_write_en,
  input  logic [31:0]              in_pixel_addr,
  input  logic [31:0]              in_pixel_word0,
  input  logic [31:0]              in_pixel_word1,
  input  logic [31:0]              in_pixel_word2,
  input  logic                     in_frame_done,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic                     out_frame_done,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  input  logic                     clear_overflow
);
  localparam int AW = $clog2(DEPTH);

  // Memory bus: a word transfers on a cycle where mem_valid & mem_ready are both
  // high; while mem_valid & !mem_ready, mem_addr/mem_wdata hold their values.
  typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;

  state_t         state_q, state_d;
  logic [127:0]   mem_q [DEPTH];
  logic [127:0]   hold_q, hold_d;
  logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           mem_valid_q, mem_valid_d;
  logic [31:0]    mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic           done_q, done_d;
  logic           pending_q, pending_d;
  logic [AW+1:0]  pend_cnt_q, pend_cnt_d;
  logic           overflow_q, overflow_d;
  logic [15:0]    drop_cnt_q, drop_cnt_d;

  logic [127:0]   in_entry, head;
  logic           hs, empty, full, load_slot, take, pop, bypass, store, drop;
  logic           pend_n;
  logic [AW+1:0]  cnt_n;
  logic [1:0]     word_k;
  logic [31:0]    pix;

  assign in_entry = {in_pixel_addr, in_pixel_word0, in_pixel_word1, in_pixel_word2};
  assign count_q  = wr_ptr_q - rd_ptr_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  // An empty FIFO forwards the incoming pixel straight into the holding register
  // so a push into an idle block appears on the bus the very next cycle.
  assign head     = empty ? in_entry : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    hs        = mem_valid_q & mem_ready;
    load_slot = (state_q == IDLE) | ((state_q == W2) & hs);
    take      = load_slot & (~empty | in_pixel_write_en);
    pop       = take & ~empty;
    bypass    = take & empty;
    store     = in_pixel_write_en & ~bypass & (~full | pop);
    drop      = in_pixel_write_en & full & ~pop;

    wr_ptr_d = store ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = wr_ptr_d - rd_ptr_d;
    hold_d   = take ? head : hold_q;

    state_d = state_q;
    case (state_q)
      IDLE: if (take) state_d = W0;
      W0:   if (hs) state_d = W1;
      W1:   if (hs) state_d = W2;
      W2:   if (hs) state_d = take ? W0 : IDLE;
      default: state_d = IDLE;
    endcase

    word_k      = 2'd0;
    mem_wdata_d = mem_wdata_q;
    case (state_d)
      W0: begin word_k = 2'd0; mem_wdata_d = hold_d[95:64]; end
      W1: begin word_k = 2'd1; mem_wdata_d = hold_d[63:32]; end
      W2: begin word_k = 2'd2; mem_wdata_d = hold_d[31:0];  end
      default: ;
    endcase
    pix         = hold_d[127:96];
    mem_valid_d = (state_d != IDLE);
    mem_addr_d  = mem_valid_d
                  ? FB_BASE + {pix[28:0], 3'b000} + {pix[29:0], 2'b00} + {28'd0, word_k, 2'b00}
                  : mem_addr_q;

    // Outstanding pixels after this edge: stored entries plus the one in flight.
    pend_n = pending_q;
    cnt_n  = pend_cnt_q;
    if (in_frame_done) begin
      pend_n = 1'b1;
      cnt_n  = {1'b0, count_d} + (AW+2)'(state_d != IDLE);
    end else if (pending_q & (state_q == W2) & hs) begin
      cnt_n = pend_cnt_q - 1'b1;
    end
    done_d     = pend_n & (cnt_n == '0);
    pending_d  = pend_n & ~done_d;
    pend_cnt_d = cnt_n;

    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q[AW-1:0]] <= in_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      pending_q   <= 1'b0;
      pend_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      pending_q   <= pending_d;
      pend_cnt_q  <= pend_cnt_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign out_frame_done = done_q;
  assign fifo_level     = count_q;
  assign overflow       = overflow_q;
  assign drop_count     = drop_cnt_q;
endmodule

// File: tb/tb_pixel_writeback_fifo.sv
// Directed bench for pixel_writeback_fifo: scoreboard of expected bus writes plus
// checks on level, overflow, frame-done timing and asynchronous reset.
module tb_pixel_writeback_fifo;
  localparam int DEPTH = 16;
  localparam logic [31:0] FB = 32'h0000_0000;

  logic        clk, rst_n;
  logic        in_pixel_write_en, in_frame_done, clear_overflow, mem_ready;
  logic [31:0] in_pixel_addr, in_pixel_word0, in_pixel_word1, in_pixel_word2;
  logic        mem_valid, out_frame_done, overflow;
  logic [31:0] mem_addr, mem_wdata;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [15:0] drop_count;

  pixel_writeback_fifo #(.DEPTH(DEPTH), .FB_BASE(FB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_pixel_write_en(in_pixel_write_en), .in_pixel_addr(in_pixel_addr),
    .in_pixel_word0(in_pixel_word0), .in_pixel_word1(in_pixel_word1),
    .in_pixel_word2(in_pixel_word2), .in_frame_done(in_frame_done),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .out_frame_done(out_frame_done), .fifo_level(fifo_level),
    .overflow(overflow), .drop_count(drop_count), .clear_overflow(clear_overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  logic [63:0] exp_q[$];
  int hs_count = 0, run_len = 0, max_run = 0, done_pulses = 0, done_cyc = -1, w2_cyc = -2;
  bit prev_hs = 0;
  logic [31:0] watch_addr = 32'hFFFF_FFFF;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n && mem_valid && mem_ready) begin
      hs_count++;
      run_len = prev_hs ? run_len + 1 : 1;
      if (run_len > max_run) max_run = run_len;
      prev_hs = 1;
      if (mem_addr == watch_addr) w2_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_write observed=%0h expected=none", {mem_addr, mem_wdata});
      end else begin
        check("write", {mem_addr, mem_wdata}, exp_q.pop_front());
      end
    end else begin
      prev_hs = 0;
    end
    if (rst_n && out_frame_done) begin
      done_pulses++;
      done_cyc = cyc;
    end
  end

  // driver tasks: called 1ns after a rising edge, return 1ns after the next one
  task automatic push_px(input logic [31:0] a, input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input bit keep);
    in_pixel_write_en = 1'b1;
    in_pixel_addr = a; in_pixel_word0 = w0; in_pixel_word1 = w1; in_pixel_word2 = w2;
    if (keep) begin
      exp_q.push_back({FB + a * 32'd12, w0});
      exp_q.push_back({FB + a * 32'd12 + 32'd4, w1});
      exp_q.push_back({FB + a * 32'd12 + 32'd8, w2});
    end
    @(posedge clk); #1;
    in_pixel_write_en = 1'b0;
  endtask

  task automatic pulse_frame_done();
    in_frame_done = 1'b1;
    @(posedge clk); #1;
    in_frame_done = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || mem_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_drain_timeout"}, 64'(n < 500), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_frame_done"}, 64'(out_frame_done), 64'd0);
    check({tag, "_fifo_level"}, 64'(fifo_level), 64'd0);
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
    check({tag, "_drop_count"}, 64'(drop_count), 64'd0);
  endtask

  initial begin
    int hs0, done0;
    rst_n = 1'b0; mem_ready = 1'b0; in_pixel_write_en = 1'b0; in_frame_done = 1'b0;
    clear_overflow = 1'b0; in_pixel_addr = '0;
    in_pixel_word0 = '0; in_pixel_word1 = '0; in_pixel_word2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single pixel, full speed
    mem_ready = 1'b1;
    max_run = 0;
    push_px(32'd5, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 1);
    @(negedge clk);
    check("latency_valid", 64'(mem_valid), 64'd1);
    check("latency_addr", 64'(mem_addr), 64'h3C);
    @(posedge clk); #1;
    wait_drain("single");
    check("single_level", 64'(fifo_level), 64'd0);
    check("single_consecutive", 64'(max_run), 64'd3);

    // backpressure during word1
    mem_ready = 1'b0;
    hs0 = hs_count;
    push_px(32'd7, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("bp_addr", 64'(mem_addr), 64'h58);
      check("bp_data", 64'(mem_wdata), 64'h2222_2222);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    wait_drain("bp");
    check("bp_handshakes", 64'(hs_count - hs0), 64'd3);

    // overflow: 1 in flight + DEPTH stored + 1 dropped
    mem_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++)
      push_px(32'd100 + 32'(i), 32'h10 * 32'(i), 32'h10 * 32'(i) + 1, 32'h10 * 32'(i) + 2,
              i < DEPTH + 1);
    check("ovf_level", 64'(fifo_level), 64'(DEPTH));
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_drops", 64'(drop_count), 64'd1);
    clear_overflow = 1'b1;
    push_px(32'd200, 32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 0);
    clear_overflow = 1'b0;
    check("clear_flag", 64'(overflow), 64'd0);
    check("clear_drops", 64'(drop_count), 64'd0);
    // push into a full FIFO on the same cycle as the word2 pop is accepted
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    push_px(32'd300, 32'hF00D_0000, 32'hF00D_0001, 32'hF00D_0002, 1);
    check("fullpop_flag", 64'(overflow), 64'd0);
    check("fullpop_level", 64'(fifo_level), 64'(DEPTH));
    wait_drain("ovf");
    check("ovf_after_drain", 64'(drop_count), 64'd0);

    // frame done with 3 pixels outstanding, then 2 more pushed
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push_px(32'h20 + 32'(i), 32'hA0 + 32'(i), 32'hB0 + 32'(i), 32'hC0 + 32'(i), 1);
    check("frame_level", 64'(fifo_level), 64'd2);
    watch_addr = FB + 32'h22 * 32'd12 + 32'd8;
    done0 = done_pulses;
    pulse_frame_done();
    push_px(32'h23, 32'hA3, 32'hB3, 32'hC3, 1);
    push_px(32'h24, 32'hA4, 32'hB4, 32'hC4, 1);
    check("frame_no_early", 64'(done_pulses - done0), 64'd0);
    mem_ready = 1'b1;
    wait_drain("frame");
    watch_addr = 32'hFFFF_FFFF;
    check("frame_pulses", 64'(done_pulses - done0), 64'd1);
    check("frame_timing", 64'(done_cyc), 64'(w2_cyc + 1));

    // frame done while idle and empty
    done0 = done_pulses;
    pulse_frame_done();
    @(negedge clk);
    check("idle_done_high", 64'(out_frame_done), 64'd1);
    @(negedge clk);
    check("idle_done_low", 64'(out_frame_done), 64'd0);
    check("idle_done_pulses", 64'(done_pulses - done0), 64'd1);
    @(posedge clk); #1;

    // back-to-back pushes
    mem_ready = 1'b1;
    max_run = 0;
    hs0 = hs_count;
    for (int i = 0; i < 10; i++)
      push_px(32'h400 + 32'(i), $urandom, $urandom, $urandom, 1);
    wait_drain("b2b");
    check("b2b_handshakes", 64'(hs_count - hs0), 64'd30);
    check("b2b_no_bubbles", 64'(max_run), 64'd30);
    check("b2b_no_drops", 64'(drop_count), 64'd0);

    // asynchronous reset in the middle of word1
    mem_ready = 1'b0;
    push_px(32'd9, 32'h9000_0000, 32'h9000_0001, 32'h9000_0002, 1);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    push_px(32'd11, 32'h1100_0000, 32'h1100_0001, 32'h1100_0002, 1);
    @(negedge clk);
    check("post_rst_addr", 64'(mem_addr), 64'(32'd132));
    check("post_rst_data", 64'(mem_wdata), 64'h1100_0000);
    @(posedge clk); #1;
    wait_drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
